alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter: NREQ, 2, number of requesters (fixed at 2 in this revision).
REQ-002 The block SHALL have port: clk  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports: req0_valid  input  1; req0_ready  output  1; req0_a  input  8; req0_b  input  8; req0_op  input  4 (aluop encoding of alu).
REQ-005 The block SHALL have ports: req1_valid, req1_ready, req1_a, req1_b, req1_op, with the same directions and widths as requester 0.
REQ-006 The block SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_o  output  8 (ALU result); rsp_id  output  1 (requester that issued the result).
REQ-007 The block SHALL have port: txn_cnt  output  16  count of completed responses, wrapping.

Function
REQ-010 The block SHALL share one combinational alu instance (a, b, o, aluop) between both requesters.
REQ-011 A request transfers when reqN_valid && reqN_ready on a rising edge; a response transfers when rsp_valid && rsp_ready.
REQ-012 The FSM SHALL have states EMPTY (rsp_valid=0) and FULL (rsp_valid=1), backed by a one-entry response register.
REQ-013 The output register SHALL be free in a cycle when state==EMPTY, or when state==FULL && rsp_ready==1.
REQ-014 When the output register is free, the block SHALL grant exactly one valid requester and assert only that requester's ready in the same cycle; ready SHALL NOT depend on reqN_ready of the other requester.
REQ-015 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester, and the pointer SHALL move to the other requester after every grant.
REQ-016 When only one requester is valid, that requester SHALL be granted regardless of the pointer.
REQ-017 On a grant, the alu SHALL be driven with the granted a/b/op, and the block SHALL register alu.o into rsp_o and the granted index into rsp_id; rsp_valid SHALL be 1 on the next cycle (latency 1).
REQ-018 In FULL with rsp_ready=1 and a grant in the same cycle, the block SHALL remain in FULL and load the new result, giving a sustained throughput of 1 result/cycle.
REQ-019 In FULL with rsp_ready=0, both readies SHALL be 0, and rsp_o/rsp_id SHALL hold stable.
REQ-020 In FULL with rsp_ready=1 and no valid request, the block SHALL move to EMPTY.
REQ-021 txn_cnt SHALL increment on each response transfer and wrap from 16'hFFFF to 0.
REQ-022 reqN_ready SHALL be 0 in any cycle where reqN_valid is 0.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set state to EMPTY, rsp_valid to 0, rsp_o to 0, rsp_id to 0, pointer to 0 (requester 0 preferred), and txn_cnt to 0.
REQ-031 During a cycle with rst=1, both readies SHALL be 0.
REQ-032 Reset SHALL discard a pending FULL result with no response transfer and no txn_cnt increment.

Structure
REQ-040 A shared package SHALL hold DATA_W=8, OP_W=4, CNT_W=16 and the state encoding (EMPTY=0, FULL=1).
REQ-041 The existing alu module SHALL be the single sub-module, instantiated once; arbitration and FSM logic SHALL be local.

Verification
REQ-050 Single request: req0 {a=64, b=2, op=0}, rsp_ready=1 -> req0_ready=1 in the same cycle; one cycle later rsp_valid=1, rsp_id=0, rsp_o equals the alu model for (64, 2, 0); txn_cnt=1.
REQ-051 Contention: both requesters valid every cycle, rsp_ready=1, 8 cycles -> grants alternate 0,1,0,1...; rsp_id alternates; 8 results in 8 consecutive cycles.
REQ-052 Backpressure: rsp_ready=0 for 5 cycles while FULL -> both readies 0; rsp_o/rsp_id unchanged; txn_cnt unchanged; the result drains on the first cycle rsp_ready=1.
REQ-053 Op sweep: req1 a=64, b=2, op=0..15 back-to-back -> 16 results in order, each equal to the alu model, all with rsp_id=1.
REQ-054 Reset mid-operation: assert rst while FULL -> rsp_valid=0 and txn_cnt=0 on the next cycle; after release with both requesters valid, requester 0 is granted first.
REQ-055 Counter wrap: preload via 65536 transfers (or force) -> txn_cnt reads 0 after transfer 65536.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   DATA_W / OP_W / CNT_W : operand, opcode and transaction-counter widths
//   state_t               : response-register FSM encoding
//   aluop_t               : opcode encoding understood by the alu module
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,   // a + b
        OP_SUB  = 4'd1,   // a - b
        OP_AND  = 4'd2,   // a & b
        OP_OR   = 4'd3,   // a | b
        OP_XOR  = 4'd4,   // a ^ b
        OP_NOR  = 4'd5,   // ~(a | b)
        OP_SLL  = 4'd6,   // a << b[2:0]
        OP_SRL  = 4'd7,   // a >> b[2:0]
        OP_SRA  = 4'd8,   // a >>> b[2:0], sign-filling
        OP_SLT  = 4'd9,   // signed a < b, result 0/1
        OP_SLTU = 4'd10,  // unsigned a < b, result 0/1
        OP_PASA = 4'd11,  // a
        OP_PASB = 4'd12,  // b
        OP_NOTA = 4'd13,  // ~a
        OP_INC  = 4'd14,  // a + 1
        OP_DEC  = 4'd15   // a - 1
    } aluop_t;

endpackage

// File: rtl/alu_arb_alu.sv
// Combinational 8-bit ALU shared by the arbiter's requesters.
//   a, b  : operands
//   aluop : operation select (aluop_t encoding)
//   o     : result
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   aluop,
    output logic [DATA_W-1:0] o
);

    always_comb begin
        o = '0;
        case (aluop_t'(aluop))
            OP_ADD:  o = a + b;
            OP_SUB:  o = a - b;
            OP_AND:  o = a & b;
            OP_OR:   o = a | b;
            OP_XOR:  o = a ^ b;
            OP_NOR:  o = ~(a | b);
            OP_SLL:  o = a << b[2:0];
            OP_SRL:  o = a >> b[2:0];
            OP_SRA:  o = $signed(a) >>> b[2:0];
            OP_SLT:  o = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: o = {{(DATA_W-1){1'b0}}, a < b};
            OP_PASA: o = a;
            OP_PASB: o = b;
            OP_NOTA: o = ~a;
            OP_INC:  o = a + 1'b1;
            OP_DEC:  o = a - 1'b1;
            default: o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a single shared ALU with a
// one-entry registered response slot.
//   clk, rst                   : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op    : request handshake and operands, N = 0,1
//   rsp_valid/ready/o/id       : response handshake, result, source requester
//   txn_cnt                    : wrapping count of completed responses
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_o,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  txn_cnt
);

    state_t            state;
    logic              ptr;     // preferred requester when both are valid
    logic [NREQ-1:0]   valid;
    logic              slot_free;
    logic              gnt;
    logic              sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_o;

    assign valid     = {req1_valid, req0_valid};
    assign rsp_valid = (state == FULL);

    // Slot is free when empty or when the held result leaves this cycle;
    // a lone valid requester wins regardless of the pointer.
    always_comb begin
        slot_free  = (state == EMPTY) || rsp_ready;
        gnt        = !rst && slot_free && (|valid);
        sel        = (&valid) ? ptr : valid[1];
        req0_ready = gnt && !sel;
        req1_ready = gnt && sel;
        alu_a      = sel ? req1_a  : req0_a;
        alu_b      = sel ? req1_b  : req0_b;
        alu_op     = sel ? req1_op : req0_op;
    end

    alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .aluop (alu_op),
        .o     (alu_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ptr     <= 1'b0;
            rsp_o   <= '0;
            rsp_id  <= 1'b0;
            txn_cnt <= '0;
        end else begin
            if (state == FULL && rsp_ready)
                txn_cnt <= txn_cnt + 1'b1;
            if (gnt) begin
                state  <= FULL;
                rsp_o  <= alu_o;
                rsp_id <= sel;
                ptr    <= ~sel;
            end else if (slot_free) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_o;
    logic [15:0] txn_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    alu_arb #(.NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_o(rsp_o), .rsp_id(rsp_id), .txn_cnt(txn_cnt)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    initial begin
        logic [15:0] base;
        // a=64, b=2, every opcode
        vecs[0]  = '{8'h40, 8'h02, 4'd0,  8'h42};
        vecs[1]  = '{8'h40, 8'h02, 4'd1,  8'h3E};
        vecs[2]  = '{8'h40, 8'h02, 4'd2,  8'h00};
        vecs[3]  = '{8'h40, 8'h02, 4'd3,  8'h42};
        vecs[4]  = '{8'h40, 8'h02, 4'd4,  8'h42};
        vecs[5]  = '{8'h40, 8'h02, 4'd5,  8'hBD};
        vecs[6]  = '{8'h40, 8'h02, 4'd6,  8'h00};
        vecs[7]  = '{8'h40, 8'h02, 4'd7,  8'h10};
        vecs[8]  = '{8'h40, 8'h02, 4'd8,  8'h10};
        vecs[9]  = '{8'h40, 8'h02, 4'd9,  8'h00};
        vecs[10] = '{8'h40, 8'h02, 4'd10, 8'h00};
        vecs[11] = '{8'h40, 8'h02, 4'd11, 8'h40};
        vecs[12] = '{8'h40, 8'h02, 4'd12, 8'h02};
        vecs[13] = '{8'h40, 8'h02, 4'd13, 8'hBF};
        vecs[14] = '{8'h40, 8'h02, 4'd14, 8'h41};
        vecs[15] = '{8'h40, 8'h02, 4'd15, 8'h3F};
        // a=F0 (negative), b=3: exercises carries, sign and shifts
        vecs[16] = '{8'hF0, 8'h03, 4'd0,  8'hF3};
        vecs[17] = '{8'hF0, 8'h03, 4'd1,  8'hED};
        vecs[18] = '{8'hF0, 8'h03, 4'd2,  8'h00};
        vecs[19] = '{8'hF0, 8'h03, 4'd3,  8'hF3};
        vecs[20] = '{8'hF0, 8'h03, 4'd4,  8'hF3};
        vecs[21] = '{8'hF0, 8'h03, 4'd5,  8'h0C};
        vecs[22] = '{8'hF0, 8'h03, 4'd6,  8'h80};
        vecs[23] = '{8'hF0, 8'h03, 4'd7,  8'h1E};
        vecs[24] = '{8'hF0, 8'h03, 4'd8,  8'hFE};
        vecs[25] = '{8'hF0, 8'h03, 4'd9,  8'h01};
        vecs[26] = '{8'hF0, 8'h03, 4'd10, 8'h00};
        vecs[27] = '{8'hF0, 8'h03, 4'd11, 8'hF0};
        vecs[28] = '{8'hF0, 8'h03, 4'd12, 8'h03};
        vecs[29] = '{8'hF0, 8'h03, 4'd13, 8'h0F};
        vecs[30] = '{8'hF0, 8'h03, 4'd14, 8'hF1};
        vecs[31] = '{8'hF0, 8'h03, 4'd15, 8'hEF};

        // ---- reset: readies held low even with a valid request
        rst = 1'b1; rsp_ready = 1'b1;
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        set1(1'b0, 8'h0, 8'h0, 4'd0);
        @(posedge clk); #1;
        set0(1'b1, 8'h11, 8'h22, 4'd0);
        set1(1'b1, 8'h33, 8'h44, 4'd0);
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_o", rsp_o, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_cnt", txn_cnt, 0);
        rst = 1'b0;

        // ---- contention: alternating grants, one result per cycle
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, 8'(10 + i), 8'h01, 4'd0);   // exp 11+i
            set1(1'b1, 8'(100 + i), 8'h01, 4'd1);  // exp 99+i
            @(negedge clk);
            chk("cont_ready0", req0_ready, (i % 2) == 0);
            chk("cont_ready1", req1_ready, (i % 2) == 1);
            @(posedge clk); #1;
            chk("cont_valid", rsp_valid, 1);
            chk("cont_id", rsp_id, i % 2);
            chk("cont_o", rsp_o, (i % 2) == 0 ? 11 + i : 99 + i);
        end
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        set1(1'b0, 8'h0, 8'h0, 4'd0);
        @(posedge clk); #1;
        chk("cont_drain_valid", rsp_valid, 0);
        chk("cont_cnt", txn_cnt, 8);

        // ---- single request, latency 1
        set0(1'b1, 8'd64, 8'd2, 4'd0);
        @(negedge clk);
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        @(posedge clk); #1;
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_o", rsp_o, 8'h42);
        @(posedge clk); #1;
        chk("single_cnt", txn_cnt, 9);
        chk("single_empty", rsp_valid, 0);

        // ---- backpressure
        rsp_ready = 1'b0;
        set0(1'b1, 8'd7, 8'd3, 4'd0);
        @(negedge clk);
        chk("bp_first_ready0", req0_ready, 1);
        @(posedge clk); #1;
        set0(1'b1, 8'd50, 8'd50, 4'd0);
        set1(1'b1, 8'd60, 8'd1, 4'd0);
        base = txn_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_o", rsp_o, 8'd10);
            chk("bp_id", rsp_id, 0);
            chk("bp_cnt", txn_cnt, base);
        end
        rsp_ready = 1'b1;
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        set1(1'b0, 8'h0, 8'h0, 4'd0);
        @(posedge clk); #1;
        chk("bp_drain_valid", rsp_valid, 0);
        chk("bp_drain_cnt", txn_cnt, base + 16'd1);

        // ---- op sweep on requester 1, back-to-back
        for (int i = 0; i < 32; i++) begin
            set1(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            @(negedge clk);
            chk("sweep_ready1", req1_ready, 1);
            @(posedge clk); #1;
            chk("sweep_valid", rsp_valid, 1);
            chk("sweep_id", rsp_id, 1);
            chk($sformatf("sweep_o[%0d]", i), rsp_o, vecs[i].exp);
        end
        set1(1'b0, 8'h0, 8'h0, 4'd0);
        @(posedge clk); #1;
        chk("sweep_cnt", txn_cnt, base + 16'd33);

        // ---- reset while FULL
        rsp_ready = 1'b0;
        set0(1'b1, 8'd1, 8'd1, 4'd0);
        @(posedge clk); #1;
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        chk("rmid_full", rsp_valid, 1);
        rst = 1'b1; rsp_ready = 1'b1;
        set0(1'b1, 8'd1, 8'd1, 4'd0);
        set1(1'b1, 8'd9, 8'd9, 4'd0);
        @(negedge clk);
        chk("rmid_ready0", req0_ready, 0);
        chk("rmid_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("rmid_valid", rsp_valid, 0);
        chk("rmid_cnt", txn_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_first_ready0", req0_ready, 1);
        chk("rmid_first_ready1", req1_ready, 0);
        @(posedge clk); #1;
        chk("rmid_first_id", rsp_id, 0);
        chk("rmid_first_o", rsp_o, 8'd2);

        // ---- counter wrap: first edge after reset only loads the slot
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_ffff", txn_cnt, 16'hFFFF);
        @(posedge clk); #1;
        chk("wrap_zero", txn_cnt, 16'h0000);
        set0(1'b0, 8'h0, 8'h0, 4'd0);
        set1(1'b0, 8'h0, 8'h0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
